branch_predictor: RTL

//  Parametrised dynamic branch predictor for the 5-stage RV32 pipeline. It replaces static
//  not-taken fetch.
//  - IF presents the current PC and gets a same-cycle taken/target prediction.
//  - ID reports resolved branches/jumps back through the update port.
//  - Holds a direct-mapped, tagged BTB and an untagged table of saturating counters.
//  - Counter table is indexed bimodal or gshare, selected by parameter.
//  - Free-running 32-bit counters record lookups and mispredicts.

---
 rtl/branch_predictor.sv | 126 ++++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped tagged BTB plus a bimodal or gshare saturating-counter table.
// Prediction is combinational from pre-edge state; resolved-branch updates land on the rising edge.
module branch_predictor #(
  parameter int ENTRIES  = 64,
  parameter int CTR_BITS = 2,
  parameter int TAG_BITS = 8,
  parameter int GSHARE   = 0,
  parameter int GHR_BITS = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] lk_pc_i,
  input  logic        lk_valid_i,
  output logic        pred_hit_o,
  output logic        pred_taken_o,
  output logic [31:0] pred_target_o,
  input  logic        upd_valid_i,
  input  logic [31:0] upd_pc_i,
  input  logic        upd_is_cond_i,
  input  logic        upd_taken_i,
  input  logic [31:0] upd_target_i,
  input  logic        upd_mispred_i,
  input  logic        flush_i,
  output logic [31:0] stat_lookups_o,
  output logic [31:0] stat_mispred_o
);

  localparam int IDX_BITS = $clog2(ENTRIES);
  localparam int TAG_LO   = IDX_BITS + 2;
  localparam int TAG_HI   = IDX_BITS + TAG_BITS + 1;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

  logic [ENTRIES-1:0]  valid_reg;
  logic [TAG_BITS-1:0] tag_mem    [ENTRIES];
  logic [31:0]         target_mem [ENTRIES];
  logic                cond_mem   [ENTRIES];
  logic [CTR_BITS-1:0] ctr_reg    [ENTRIES];
  logic [GHR_BITS-1:0] ghr_reg;
  logic [GHR_BITS-1:0] ghr_next;
  logic [31:0]         lookups_reg;
  logic [31:0]         mispred_reg;

  logic [IDX_BITS-1:0] ghr_fold;
  logic [IDX_BITS-1:0] lk_idx;
  logic [IDX_BITS-1:0] lk_cidx;
  logic [TAG_BITS-1:0] lk_tag;
  logic                lk_hit;
  logic                lk_taken;
  logic [IDX_BITS-1:0] upd_idx;
  logic [IDX_BITS-1:0] upd_cidx;
  logic [TAG_BITS-1:0] upd_tag;
  logic                upd_cond;
  logic                btb_write;
  logic [CTR_BITS-1:0] ctr_cur;
  logic [CTR_BITS-1:0] ctr_next;

  // History bits beyond GHR_BITS read as zero, so short histories still elaborate.
  for (genvar gi = 0; gi < IDX_BITS; gi++) begin : g_fold
    if (gi < GHR_BITS) begin : g_bit
      assign ghr_fold[gi] = ghr_reg[gi];
    end else begin : g_zero
      assign ghr_fold[gi] = 1'b0;
    end
  end

  assign lk_idx   = lk_pc_i[TAG_LO-1:2];
  assign lk_tag   = lk_pc_i[TAG_HI:TAG_LO];
  assign lk_cidx  = (GSHARE != 0) ? (lk_idx ^ ghr_fold) : lk_idx;
  assign upd_idx  = upd_pc_i[TAG_LO-1:2];
  assign upd_tag  = upd_pc_i[TAG_HI:TAG_LO];
  assign upd_cidx = (GSHARE != 0) ? (upd_idx ^ ghr_fold) : upd_idx;

  assign lk_hit        = valid_reg[lk_idx] && (tag_mem[lk_idx] == lk_tag);
  assign lk_taken      = lk_hit && (!cond_mem[lk_idx] || ctr_reg[lk_cidx][CTR_BITS-1]);
  assign pred_hit_o    = lk_hit;
  assign pred_taken_o  = lk_taken;
  assign pred_target_o = lk_taken ? target_mem[lk_idx] : lk_pc_i + 32'd4;

  assign upd_cond  = upd_valid_i && upd_is_cond_i;
  assign btb_write = upd_valid_i && upd_taken_i && !flush_i;
  assign ctr_cur   = ctr_reg[upd_cidx];
  assign ghr_next  = GHR_BITS'({ghr_reg, upd_taken_i});

  always_comb begin
    ctr_next = ctr_cur;
    if (upd_taken_i) begin
      if (ctr_cur != CTR_MAX) ctr_next = ctr_cur + 1'b1;
    end else if (ctr_cur != '0) begin
      ctr_next = ctr_cur - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_reg   <= '0;
      ghr_reg     <= '0;
      lookups_reg <= '0;
      mispred_reg <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_reg[i] <= CTR_INIT;
    end else begin
      // Flush beats a same-cycle BTB install; counters and history still train.
      if (flush_i) valid_reg <= '0;
      else if (btb_write) valid_reg[upd_idx] <= 1'b1;
      if (upd_cond) begin
        ctr_reg[upd_cidx] <= ctr_next;
        ghr_reg           <= ghr_next;
      end
      if (lk_valid_i) lookups_reg <= lookups_reg + 32'd1;
      if (upd_valid_i && upd_mispred_i) mispred_reg <= mispred_reg + 32'd1;
    end
  end

  // BTB payload is qualified by valid_reg, so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i && btb_write) begin
      tag_mem[upd_idx]    <= upd_tag;
      target_mem[upd_idx] <= {upd_target_i[31:1], 1'b0};
      cond_mem[upd_idx]   <= upd_is_cond_i;
    end
  end

  assign stat_lookups_o = lookups_reg;
  assign stat_mispred_o = mispred_reg;

endmodule
